// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared sizing defaults for the IF->ID fetch queue
package fetch_queue_pkg;
  localparam int FQ_WORD_WIDTH = 32;
  localparam int FQ_DEPTH      = 4;
endpackage

// File: rtl/fq_storage.sv
// rtl/fq_storage.sv - fetch queue entry array, one write port and one async read port
// Contents are not reset; validity is tracked entirely by the owning queue.
module fq_storage #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - IF->ID decoupling FIFO of {PC, instruction} pairs with flush
// Optional same-cycle empty bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int WORD_WIDTH = FQ_WORD_WIDTH,
  parameter int DEPTH      = FQ_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [WORD_WIDTH-1:0]   wr_pc,
  input  logic [WORD_WIDTH-1:0]   wr_instr,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [WORD_WIDTH-1:0]   rd_pc,
  output logic [WORD_WIDTH-1:0]   rd_instr,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [2*WORD_WIDTH-1:0] head;
  logic                    stored_valid, bypass, push, pop, store, deq;

  assign stored_valid = (count != '0);
  assign wr_ready     = (count != FULL);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = !stored_valid && wr_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign rd_valid = stored_valid | bypass;
  assign push     = wr_valid & wr_ready & ~flush;
  assign pop      = rd_valid & rd_ready & ~flush;
  // A bypassed entry taken by ID in the same cycle never touches the array.
  assign store    = push & ~(bypass & rd_ready);
  assign deq      = pop & ~bypass;

  always_comb begin
    rd_pc    = '0;
    rd_instr = '0;
    if (stored_valid) begin
      {rd_pc, rd_instr} = head;
    end else if (bypass) begin
      rd_pc    = wr_pc;
      rd_instr = wr_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PW'(1);
      if (deq)   rd_ptr <= rd_ptr + PW'(1);
      if (store && !deq)      count <= count + CW'(1);
      else if (deq && !store) count <= count - CW'(1);
    end
  end

  fq_storage #(
    .DEPTH     (DEPTH),
    .DATA_WIDTH(2 * WORD_WIDTH),
    .ADDR_WIDTH(PW)
  ) u_storage (
    .clk    (clk),
    .wr_en  (store),
    .wr_addr(wr_ptr),
    .wr_data({wr_pc, wr_instr}),
    .rd_addr(rd_ptr),
    .rd_data(head)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue (either FETCH_QUEUE_BYPASS_EN build)
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_pc;
  logic [31:0] wr_instr;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_pc;
  logic [31:0] rd_instr;
  logic [2:0]  count;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int got_pcs[$];

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  fetch_queue dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_pc   (wr_pc),
    .wr_instr(wr_instr),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_pc   (rd_pc),
    .rd_instr(rd_instr),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int pc, input logic rr, input logic fl);
    wr_valid = v;
    wr_pc    = 32'(pc);
    wr_instr = 32'hA000_0000 | 32'(pc);
    rd_ready = rr;
    flush    = fl;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0);
    #2;
    check("reset_count",    64'(count),    64'd0);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_rd_pc",    64'(rd_pc),    64'd0);
    check("reset_rd_instr", 64'(rd_instr), 64'd0);
    check("reset_wr_ready", 64'(wr_ready), 64'd1);
    tick();
    rst = 1'b1;
    tick();

    // Fill with PC 1..4 while ID stalls.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 0, 1'b0, 1'b0);
    #1;
    check("fill_count",    64'(count),    64'd4);
    check("fill_wr_ready", 64'(wr_ready), 64'd0);
    check("fill_head_pc",  64'(rd_pc),    64'd1);
    drive(1'b1, 5, 1'b0, 1'b0);
    tick();
    check("full_push_dropped_count", 64'(count), 64'd4);

    // Full: pop PC=1, concurrent push of PC=6 dropped.
    drive(1'b1, 6, 1'b1, 1'b0);
    #1;
    check("full_pop_pc",       64'(rd_pc),    64'd1);
    check("full_pop_wr_ready", 64'(wr_ready), 64'd0);
    tick();
    drive(1'b0, 0, 1'b0, 1'b0);
    #1;
    check("after_full_pop_count",    64'(count),    64'd3);
    check("after_full_pop_wr_ready", 64'(wr_ready), 64'd1);

    // Drain the rest: 2,3,4 (PC 5 and 6 must never show up).
    for (int i = 2; i <= 4; i++) begin
      drive(1'b0, 0, 1'b1, 1'b0);
      #1;
      check($sformatf("drain_valid_%0d", i), 64'(rd_valid), 64'd1);
      check($sformatf("drain_pc_%0d", i),    64'(rd_pc),    64'(i));
      check($sformatf("drain_instr_%0d", i), 64'(rd_instr), 64'(32'hA000_0000 | 32'(i)));
      tick();
    end
    drive(1'b0, 0, 1'b1, 1'b0);
    #1;
    check("empty_count",    64'(count),    64'd0);
    check("empty_rd_valid", 64'(rd_valid), 64'd0);
    check("empty_rd_pc",    64'(rd_pc),    64'd0);
    tick();
    check("empty_no_underflow", 64'(count), 64'd0);

    // Flush with 3 entries and a concurrent push of PC=9 and pop.
    for (int i = 10; i <= 12; i++) begin
      drive(1'b1, i, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 9, 1'b1, 1'b1);
    #1;
    check("pre_flush_count", 64'(count), 64'd3);
    tick();
    drive(1'b0, 0, 1'b1, 1'b0);
    #1;
    check("flush_count",    64'(count),    64'd0);
    check("flush_rd_valid", 64'(rd_valid), 64'd0);
    tick();
    check("flush_pc9_absent", 64'(rd_valid), 64'd0);

    // Empty queue, push PC=7 with ID ready.
    drive(1'b1, 7, 1'b1, 1'b0);
    #1;
    check("byp_same_cycle_valid", 64'(rd_valid), BYP ? 64'd1 : 64'd0);
    check("byp_same_cycle_pc",    64'(rd_pc),    BYP ? 64'd7 : 64'd0);
    tick();
    drive(1'b0, 0, 1'b1, 1'b0);
    #1;
    check("byp_next_count", 64'(count),    BYP ? 64'd0 : 64'd1);
    check("byp_next_valid", 64'(rd_valid), BYP ? 64'd0 : 64'd1);
    check("byp_next_pc",    64'(rd_pc),    BYP ? 64'd0 : 64'd7);
    tick();
    check("byp_final_count", 64'(count), 64'd0);

    // Streaming PC 1..20 with both sides always ready.
    got_pcs.delete();
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, i, 1'b1, 1'b0);
      #1;
      if (i > 1 || BYP) check($sformatf("stream_valid_%0d", i), 64'(rd_valid), 64'd1);
      if (i > 1) check($sformatf("stream_count_%0d", i), 64'(count), BYP ? 64'd0 : 64'd1);
      if (rd_valid) got_pcs.push_back(int'(rd_pc));
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 0, 1'b1, 1'b0);
      #1;
      if (rd_valid) got_pcs.push_back(int'(rd_pc));
      tick();
    end
    check("stream_total", 64'(got_pcs.size()), 64'd20);
    for (int i = 0; i < got_pcs.size() && i < 20; i++)
      check($sformatf("stream_order_%0d", i), 64'(got_pcs[i]), 64'(i + 1));
    check("stream_end_count", 64'(count), 64'd0);

    // Asynchronous reset in the middle of a cycle with entries held.
    drive(1'b1, 30, 1'b0, 1'b0);
    tick();
    drive(1'b1, 31, 1'b0, 1'b0);
    tick();
    drive(1'b0, 0, 1'b0, 1'b0);
    #1;
    check("pre_rst_count", 64'(count), 64'd2);
    rst = 1'b0;
    #1;
    check("async_rst_count",    64'(count),    64'd0);
    check("async_rst_rd_valid", 64'(rd_valid), 64'd0);
    check("async_rst_rd_instr", 64'(rd_instr), 64'd0);
    check("async_rst_wr_ready", 64'(wr_ready), 64'd1);
    tick();
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
